// File: rtl/soc_system_coproc_reset_seq_if.sv
// Image RAM write port driven by the coprocessor reset sequencer.
interface soc_system_coproc_reset_seq_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 8
);
    logic              mem_wr_ready;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;

    modport master (
        input  mem_wr_ready,
        output mem_wr_en,
        output mem_wr_addr,
        output mem_wr_data
    );

    modport slave (
        output mem_wr_ready,
        input  mem_wr_en,
        input  mem_wr_addr,
        input  mem_wr_data
    );
endinterface

// File: rtl/soc_system_coproc_reset_seq.sv
// Sequenced coprocessor reset: hold the core in reset, sweep-clear the image RAM,
// then release and strobe completion. Triggered by power-up or a rising PIO level.
module soc_system_coproc_reset_seq #(
    parameter int unsigned          HOLD_CYCLES = 16,
    parameter int unsigned          ADDR_W      = 17,
    parameter int unsigned          MEM_DEPTH   = 76800,
    parameter int unsigned          DATA_W      = 8,
    parameter logic [DATA_W-1:0]    CLEAR_VALUE = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            pio_reset_in,
    soc_system_coproc_reset_seq_if.master   mem,
    output logic                            coproc_reset_out,
    output logic                            busy,
    output logic                            done_pulse
);
    localparam int unsigned       HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [HOLD_W-1:0] hold_cnt, hold_next;
    logic [ADDR_W-1:0] addr, addr_next;
    logic              req_d;
    logic              rise;

    // req_d resets high so a level already asserted at power-up is not a request
    assign rise = pio_reset_in & ~req_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= HOLD;
            hold_cnt <= '0;
            addr     <= '0;
            req_d    <= 1'b1;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
            addr     <= addr_next;
            req_d    <= pio_reset_in;
        end
    end

    // Next-state; a new request restarts the sequence from any non-idle state
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        addr_next  = addr;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = HOLD;
                    hold_next  = '0;
                    addr_next  = '0;
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_next = CLEAR;
                    hold_next  = '0;
                    addr_next  = '0;
                end else begin
                    hold_next = hold_cnt + HOLD_W'(1);
                end
            end
            CLEAR: begin
                if (mem.mem_wr_ready) begin
                    if (addr == ADDR_LAST) begin
                        state_next = DONE;
                        addr_next  = '0;
                    end else begin
                        addr_next = addr + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (rise && (state != IDLE)) begin
            state_next = HOLD;
            hold_next  = '0;
            addr_next  = '0;
        end
    end

    // Moore output decode
    always_comb begin
        coproc_reset_out = 1'b0;
        busy             = 1'b1;
        done_pulse       = 1'b0;
        mem.mem_wr_en    = 1'b0;
        mem.mem_wr_addr  = '0;
        mem.mem_wr_data  = CLEAR_VALUE;
        case (state)
            IDLE: begin
                busy = 1'b0;
            end
            HOLD: begin
                coproc_reset_out = 1'b1;
            end
            CLEAR: begin
                coproc_reset_out = 1'b1;
                mem.mem_wr_en    = 1'b1;
                mem.mem_wr_addr  = addr;
            end
            DONE: begin
                done_pulse = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_soc_system_coproc_reset_seq.sv
// Directed bench for the coprocessor reset sequencer (HOLD_CYCLES=4, MEM_DEPTH=8).
module tb_soc_system_coproc_reset_seq;
    logic clk = 1'b0;
    logic reset;
    logic pio_reset_in;
    logic coproc_reset_out;
    logic busy;
    logic done_pulse;

    int vectors     = 0;
    int miscompares = 0;

    soc_system_coproc_reset_seq_if #(.ADDR_W(3), .DATA_W(8)) mem_if ();

    soc_system_coproc_reset_seq #(
        .HOLD_CYCLES (4),
        .ADDR_W      (3),
        .MEM_DEPTH   (8),
        .DATA_W      (8),
        .CLEAR_VALUE (8'h00)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pio_reset_in     (pio_reset_in),
        .mem              (mem_if.master),
        .coproc_reset_out (coproc_reset_out),
        .busy             (busy),
        .done_pulse       (done_pulse)
    );

    always #5 clk = ~clk;

    // {coproc_reset_out, wr_en, wr_addr[2:0], wr_data[7:0], busy, done_pulse}
    logic [14:0] obs;
    assign obs = {coproc_reset_out, mem_if.mem_wr_en, mem_if.mem_wr_addr,
                  mem_if.mem_wr_data, busy, done_pulse};

    // Expected outputs k cycles into an unstalled sequence (k=0 is first HOLD cycle)
    function automatic logic [14:0] seq_exp(input int k);
        if (k < 4)       return {1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0};
        else if (k < 12) return {1'b1, 1'b1, 3'(k - 4), 8'h00, 1'b1, 1'b0};
        else if (k == 12) return {1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1};
        else             return {1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
    endfunction

    // Backpressure script: address presented and ready driven per CLEAR cycle
    logic [2:0] bp_addr [0:13] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3,
                                   3'd4, 3'd5, 3'd5, 3'd5, 3'd5, 3'd6, 3'd7};
    logic       bp_rdy  [0:13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    task automatic test_reset();
        reset = 1'b1;
        pio_reset_in = 1'b0;
        mem_if.mem_wr_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (obs !== seq_exp(0)) begin
                miscompares++;
                $display("FAIL reset_state cycle %0d: got %h expected %h", c, obs, seq_exp(0));
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== seq_exp(k)) begin
                miscompares++;
                $display("FAIL powerup_seq k=%0d: got %h expected %h", k, obs, seq_exp(k));
            end
        end
    endtask

    task automatic test_sw_request();
        int busy_cnt = 0;
        int done_cnt = 0;
        pio_reset_in = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (c <= 13) begin
                vectors++;
                if (obs !== seq_exp(c)) begin
                    miscompares++;
                    $display("FAIL sw_request k=%0d: got %h expected %h", c, obs, seq_exp(c));
                end
            end
            busy_cnt += int'(busy);
            done_cnt += int'(done_pulse);
        end
        vectors++;
        if (busy_cnt !== 13 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL level_no_retrigger: busy=%0d done=%0d expected busy=13 done=1", busy_cnt, done_cnt);
        end
        pio_reset_in = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs !== seq_exp(13)) begin
            miscompares++;
            $display("FAIL idle_after_drop: got %h expected %h", obs, seq_exp(13));
        end
        pio_reset_in = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            busy_cnt += int'(busy);
            done_cnt += int'(done_pulse);
        end
        vectors++;
        if (busy_cnt !== 13 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL second_request: busy=%0d done=%0d expected busy=13 done=1", busy_cnt, done_cnt);
        end
        pio_reset_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int done_c  = -1;
        int accepts = 0;
        pio_reset_in = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) pio_reset_in = 1'b0;
            if (done_pulse) begin
                done_c = c;
                break;
            end
            if (c < 4) begin
                vectors++;
                if (obs !== seq_exp(c)) begin
                    miscompares++;
                    $display("FAIL bp_hold c=%0d: got %h expected %h", c, obs, seq_exp(c));
                end
            end else if (c < 18) begin
                vectors++;
                if (mem_if.mem_wr_en !== 1'b1 || mem_if.mem_wr_addr !== bp_addr[c-4]) begin
                    miscompares++;
                    $display("FAIL bp_addr c=%0d: got en=%b addr=%0d expected en=1 addr=%0d",
                             c, mem_if.mem_wr_en, mem_if.mem_wr_addr, bp_addr[c-4]);
                end
                mem_if.mem_wr_ready = bp_rdy[c-4];
                if (mem_if.mem_wr_en && bp_rdy[c-4]) accepts++;
            end
        end
        mem_if.mem_wr_ready = 1'b1;
        vectors++;
        if (done_c !== 18 || accepts !== 8) begin
            miscompares++;
            $display("FAIL bp_done: done at %0d with %0d writes, expected 18 with 8", done_c, accepts);
        end
        @(negedge clk);
    endtask

    task automatic test_restart();
        int done_cnt = 0;
        pio_reset_in = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            if (c == 0) pio_reset_in = 1'b0;
            done_cnt += int'(done_pulse);
        end
        vectors++;
        if (obs !== seq_exp(9)) begin
            miscompares++;
            $display("FAIL restart_at_addr5: got %h expected %h", obs, seq_exp(9));
        end
        pio_reset_in = 1'b1;
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            if (k == 0) pio_reset_in = 1'b0;
            done_cnt += int'(done_pulse);
            vectors++;
            if (obs !== seq_exp(k)) begin
                miscompares++;
                $display("FAIL restart_seq k=%0d: got %h expected %h", k, obs, seq_exp(k));
            end
        end
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL restart_done_count: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        pio_reset_in = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c == 0) pio_reset_in = 1'b0;
        end
        vectors++;
        if (obs !== seq_exp(7)) begin
            miscompares++;
            $display("FAIL reset_mid_addr3: got %h expected %h", obs, seq_exp(7));
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== seq_exp(0)) begin
            miscompares++;
            $display("FAIL reset_mid_state: got %h expected %h", obs, seq_exp(0));
        end
        reset = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== seq_exp(k)) begin
                miscompares++;
                $display("FAIL reset_mid_seq k=%0d: got %h expected %h", k, obs, seq_exp(k));
            end
        end
    endtask

    task automatic test_back_to_back();
        pio_reset_in = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            if (c == 0) pio_reset_in = 1'b0;
            vectors++;
            if (obs !== seq_exp(c)) begin
                miscompares++;
                $display("FAIL b2b_first k=%0d: got %h expected %h", c, obs, seq_exp(c));
            end
        end
        pio_reset_in = 1'b1;
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            if (k == 0) pio_reset_in = 1'b0;
            vectors++;
            if (obs !== seq_exp(k)) begin
                miscompares++;
                $display("FAIL b2b_second k=%0d: got %h expected %h", k, obs, seq_exp(k));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", miscompares);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sw_request();
        test_backpressure();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
